// File: rtl/sram_controller.sv
// 32-bit load/store port onto a 16-bit asynchronous SRAM, split into low then high half-word accesses.
// Latency 2*(WAIT_CYCLES+1)+1 cycles per access; ready drops as soon as a request is seen and returns for one DONE cycle.
// Backpressure: ready=0 freezes the requesting pipeline; inputs are latched on acceptance and ignored afterwards.
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] DATA_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int            CW      = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST    = CW'(WAIT_CYCLES);
    localparam logic          WE_HALF = (WAIT_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          op_wr;
    logic [15:0]   wdata_hi;
    logic [15:0]   rd_lo;
    logic          dq_oe;
    logic [15:0]   dq_out;
    logic [31:0]   offset;
    logic          unused_offset_bits;

    assign offset             = address - DATA_BASE;
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
    assign cnt_nxt            = cnt + CW'(1);

    assign ready     = (state == IDLE) ? !(wr_en || rd_en) : (state == DONE);
    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // Strobes are registered alongside the state; the final cycle of each half holds data with WE_N high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            wdata_hi  <= '0;
            rd_lo     <= '0;
            read_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_CE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        state     <= LOW;
                        cnt       <= '0;
                        op_wr     <= wr_en;
                        wdata_hi  <= write_data[31:16];
                        SRAM_ADDR <= {offset[18:2], 1'b0};
                        SRAM_CE_N <= 1'b0;
                        SRAM_OE_N <= wr_en;
                        SRAM_WE_N <= !(wr_en && WE_HALF);
                        dq_oe     <= wr_en;
                        dq_out    <= write_data[15:0];
                    end
                end
                LOW: begin
                    if (cnt == LAST) begin
                        state        <= HIGH;
                        cnt          <= '0;
                        SRAM_ADDR[0] <= 1'b1;
                        SRAM_WE_N    <= !(op_wr && WE_HALF);
                        dq_out       <= wdata_hi;
                        if (!op_wr)
                            rd_lo <= SRAM_DQ;
                    end else begin
                        cnt       <= cnt_nxt;
                        SRAM_WE_N <= !(op_wr && (cnt_nxt != LAST));
                    end
                end
                HIGH: begin
                    if (cnt == LAST) begin
                        state     <= DONE;
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        // Both halves land together so read_data never shows a half-updated word.
                        if (!op_wr)
                            read_data <= {SRAM_DQ, rd_lo};
                    end else begin
                        cnt       <= cnt_nxt;
                        SRAM_WE_N <= !(op_wr && (cnt_nxt != LAST));
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM array model, cycle-timeline reference model, directed accesses.
module tb_sram_controller;

    localparam int          W    = 2;
    localparam int          N    = W + 1;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_en, rd_en, ready;
    logic [31:0] address, write_data, read_data;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    logic        z_rst, z_wr, z_rd, z_ready;
    logic [31:0] z_address, z_wdata, z_rdata;
    wire  [15:0] z_dq;
    logic [17:0] z_sram_addr;
    logic        z_we_n, z_oe_n, z_ce_n, z_ub_n, z_lb_n;

    sram_controller #(.WAIT_CYCLES(W), .DATA_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
        .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    sram_controller #(.WAIT_CYCLES(0), .DATA_BASE(BASE)) dut0 (
        .clk(clk), .rst(z_rst), .wr_en(z_wr), .rd_en(z_rd), .address(z_address),
        .write_data(z_wdata), .read_data(z_rdata), .ready(z_ready), .SRAM_DQ(z_dq),
        .SRAM_ADDR(z_sram_addr), .SRAM_WE_N(z_we_n), .SRAM_OE_N(z_oe_n), .SRAM_CE_N(z_ce_n),
        .SRAM_UB_N(z_ub_n), .SRAM_LB_N(z_lb_n)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM device: drives the bus on reads, stores on any cycle with CE and WE both low.
    logic [15:0] mem     [0:262143];
    logic [15:0] exp_mem [0:262143];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'bz;

    // Reference model: el counts cycles since acceptance; 1..N low half, N+1..2N high half, 2N+1 done.
    int          el     = 0;
    bit          chk_en = 1'b0;
    logic        m_wr   = 1'b0;
    logic [16:0] m_wa   = '0;
    logic [31:0] m_wd   = '0;
    logic [31:0] m_rdata = '0;
    logic [17:0] m_sa   = '0;
    logic [31:0] diff;
    int          we_low = 0;

    always @(posedge clk) begin
        if (!ce_n && !we_n)
            mem[sram_addr] = sram_dq;
        if (rst) begin
            el = 0; m_rdata = '0; m_sa = '0; m_wr = 1'b0; chk_en = 1'b1;
        end else if (el == 0) begin
            if (wr_en || rd_en) begin
                el = 1; m_wr = wr_en; m_wd = write_data;
                diff = address - BASE;
                m_wa = diff[18:2];
            end
        end else if (el == 2*N + 1) begin
            el = 0;
        end else begin
            el++;
            if (el == 2*N + 1) begin
                if (m_wr) begin
                    exp_mem[{m_wa, 1'b0}] = m_wd[15:0];
                    exp_mem[{m_wa, 1'b1}] = m_wd[31:16];
                end else begin
                    m_rdata = {exp_mem[{m_wa, 1'b1}], exp_mem[{m_wa, 1'b0}]};
                end
            end
        end
        if (el >= 1 && el <= 2*N)
            m_sa = {m_wa, (el > N) ? 1'b1 : 1'b0};
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit   act  = (el >= 1 && el <= 2*N);
            automatic int   pos  = (el - 1) % N;
            automatic logic erdy = (el == 0) ? !(wr_en || rd_en) : (el == 2*N + 1);
            check("ready", ready, erdy);
            check("ce_n", ce_n, !act);
            check("oe_n", oe_n, !(act && !m_wr));
            check("we_n", we_n, !(act && m_wr && pos < N - 1));
            check("sram_addr", sram_addr, m_sa);
            check("read_data", read_data, m_rdata);
            check("byte_lanes", {ub_n, lb_n}, 2'b00);
            if (act && m_wr)
                check("dq_write", sram_dq, (el > N) ? m_wd[31:16] : m_wd[15:0]);
            if (!we_n)
                we_low++;
        end
    end

    // Called at posedge+1 in IDLE; returns lat = cycles from request to the n_done-th ready pulse.
    task automatic run(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input int drop_after, input int n_done, output int lat);
        int k    = 0;
        int seen = 0;
        lat = -1;
        wr_en = w; rd_en = r; address = a; write_data = d;
        while (k < 60) begin
            @(negedge clk);
            if (ready) begin
                seen++;
                if (seen == n_done) begin
                    lat = k;
                    break;
                end
            end
            @(posedge clk); #1;
            k++;
            if (k == drop_after) begin
                wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_FFFF; write_data = 32'h0;
            end
        end
        if (lat < 0)
            check("access_timeout", 32'(k), 32'd0);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        int lat;
        int zlat;
        int zwe;
        for (int i = 0; i < 262144; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        mem[18'h3FFFE] = 16'h1111; exp_mem[18'h3FFFE] = 16'h1111;
        mem[18'h3FFFF] = 16'h2222; exp_mem[18'h3FFFF] = 16'h2222;

        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0; address = BASE; write_data = 32'h5555_5555;
        z_rst = 1'b1; z_wr = 1'b0; z_rd = 1'b0; z_address = '0; z_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read_data", read_data, 32'h0);
        check("rst_sram_addr", sram_addr, 18'h0);
        check("rst_strobes", {ce_n, we_n, oe_n}, 3'b111);
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("no_accept_in_rst", ce_n, 1'b1);
        @(posedge clk); #1;

        we_low = 0;
        run(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 0, 1, lat);
        check("wr_latency", lat, 7);
        check("wr_half2", mem[2], 16'hBEEF);
        check("wr_half3", mem[3], 16'hDEAD);
        check("wr_we_low_cycles", we_low, 4);

        run(1'b0, 1'b1, 32'd1028, 32'h0, 0, 1, lat);
        check("rd_latency", lat, 7);
        check("rd_data", read_data, 32'hDEAD_BEEF);

        run(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 0, 1, lat);
        check("both_latency", lat, 7);
        check("both_rd_unchanged", read_data, 32'hDEAD_BEEF);
        check("both_half0", mem[0], 16'h5678);
        check("both_half1", mem[1], 16'h1234);

        run(1'b1, 1'b0, 32'd1032, 32'hCAFE_F00D, 2, 1, lat);
        check("withdrawn_latency", lat, 7);
        check("withdrawn_half4", mem[4], 16'hF00D);
        check("withdrawn_half5", mem[5], 16'hCAFE);

        run(1'b0, 1'b1, 32'd1020, 32'h0, 0, 2, lat);
        check("b2b_latency", lat, 15);
        check("b2b_wrap_data", read_data, 32'h2222_1111);

        rd_en = 1'b1; address = 32'd1028;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_read_data", read_data, 32'h0);
        check("abort_ce_n", ce_n, 1'b1);
        check("abort_ready", ready, 1'b1);
        @(posedge clk); #1;

        run(1'b0, 1'b1, 32'd1028, 32'h0, 0, 1, lat);
        check("recover_latency", lat, 7);
        check("recover_data", read_data, 32'hDEAD_BEEF);

        // Zero-wait configuration: each half is a single hold cycle, so WE_N never asserts.
        z_rst = 1'b0;
        @(posedge clk); #1;
        z_wr = 1'b1; z_address = 32'd1032; z_wdata = 32'hA5A5_5A5A;
        zlat = -1; zwe = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!z_we_n) zwe++;
            if (k == 1) check("cfg0_addr_lo", z_sram_addr, 18'd4);
            if (k == 2) check("cfg0_addr_hi", z_sram_addr, 18'd5);
            if (z_ready) begin
                zlat = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        z_wr = 1'b0;
        check("cfg0_latency", zlat, 3);
        check("cfg0_we_never_low", zwe, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
